vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: sync strobes, blank flag and pixel coordinates for one display.
// Latency: plain wires; the producer registers every signal.
// Backpressure: none; timing free-runs and consumers sample on the falling pixel-clock edge.
// Ports: hs/vs (active-low sync), blank (1 = visible), DrawX/DrawY (coordinates),
//        frame_start (pulse at 0,0), frame_cnt (only with VGA_FRAME_CNT_EN).
interface vga_timing_gen_if;
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    modport master (output hs, output vs, output blank, output DrawX, output DrawY,
                    output frame_start, output frame_cnt);
    modport slave  (input hs, input vs, input blank, input DrawX, input DrawY,
                    input frame_start, input frame_cnt);
`else
    modport master (output hs, output vs, output blank, output DrawX, output DrawY,
                    output frame_start);
    modport slave  (input hs, input vs, input blank, input DrawX, input DrawY,
                    input frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered sync/blank decode.
// Latency: flags are decoded from next counter values, so they align with DrawX/DrawY on every cycle.
// Backpressure: none; advances one pixel per vga_clk regardless of consumers.
// Ports: vga_clk (pixel clock), reset_n (async active-low), vga (master modport of vga_timing_gen_if).
// Optional: define VGA_FRAME_CNT_EN to add an 8-bit wrapping frame counter on vga.frame_cnt.
// H_TOTAL and V_TOTAL must each be <= 1024 so the 10-bit counters never overflow.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits so an end bound equal to 1024 is still representable.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
`endif

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end

        // Flags come from the next counter values so they land in the same
        // register stage as the coordinates they describe.
        blank_d       = ({1'b0, hc_d} < H_VIS_END) && ({1'b0, vc_d} < V_VIS_END);
        hs_d          = !(({1'b0, hc_d} >= H_SYNC_BEG) && ({1'b0, hc_d} < H_SYNC_END));
        vs_d          = !(({1'b0, vc_d} >= V_SYNC_BEG) && ({1'b0, vc_d} < V_SYNC_END));
        frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
`ifdef VGA_FRAME_CNT_EN
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
`endif
    end

    // Reset parks the raster on the last pixel of a frame, so the first edge
    // after release lands on (0,0) with a frame_start pulse.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= 8'd0;
`endif
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.blank       = blank_q;
    assign vga.frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
    assign vga.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    localparam int BIG_HT   = 800;
    localparam int BIG_T    = 800 * 525;
    localparam int SMALL_HT = 15;
    localparam int SMALL_T  = 15 * 7;

    typedef struct {
        int x;
        int y;
        int hs;
        int vs;
        int blank;
        int fs;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_big = 1'b0;
    logic rst_small = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int p_big    = BIG_T - 1;
    int p_small  = SMALL_T - 1;
    int fc_big   = 0;
    int fc_small = 0;

    exp_t q_big[$];
    exp_t q_small[$];

    // Frame statistics for the small-raster instance, gathered between frame_start pulses.
    int s_seen    = 0;
    int s_last    = 0;
    int s_pulses  = 0;
    int s_blank   = 0;
    int s_vs_low  = 0;
    int s_hs_low  = 0;

    vga_timing_gen_if vif ();
    vga_timing_gen_if sif ();

    vga_timing_gen u_big (
        .vga_clk (clk),
        .reset_n (rst_big),
        .vga     (vif)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) u_small (
        .vga_clk (clk),
        .reset_n (rst_small),
        .vga     (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference raster: position p counts pixels from the start of a frame.
    function automatic exp_t model(input int p, input int fc,
                                   input int hv, input int hfp, input int hsy, input int hbp,
                                   input int vv, input int vfp, input int vsy, input int vbp);
        exp_t e;
        int ht, vt;
        ht = hv + hfp + hsy + hbp;
        vt = vv + vfp + vsy + vbp;
        e.x     = p % ht;
        e.y     = (p / ht) % vt;
        e.blank = ((e.x < hv) && (e.y < vv)) ? 1 : 0;
        e.hs    = ((e.x >= hv + hfp) && (e.x < hv + hfp + hsy)) ? 0 : 1;
        e.vs    = ((e.y >= vv + vfp) && (e.y < vv + vfp + vsy)) ? 0 : 1;
        e.fs    = (p == 0) ? 1 : 0;
        e.fc    = fc;
        return e;
    endfunction

    task automatic compare_big(input exp_t e);
        check("big_x",     32'(vif.DrawX),       32'(e.x));
        check("big_y",     32'(vif.DrawY),       32'(e.y));
        check("big_hs",    32'(vif.hs),          32'(e.hs));
        check("big_vs",    32'(vif.vs),          32'(e.vs));
        check("big_blank", 32'(vif.blank),       32'(e.blank));
        check("big_fs",    32'(vif.frame_start), 32'(e.fs));
`ifdef VGA_FRAME_CNT_EN
        check("big_fc",    32'(vif.frame_cnt),   32'(e.fc));
`endif
    endtask

    task automatic compare_small(input exp_t e);
        check("small_x",     32'(sif.DrawX),       32'(e.x));
        check("small_y",     32'(sif.DrawY),       32'(e.y));
        check("small_hs",    32'(sif.hs),          32'(e.hs));
        check("small_vs",    32'(sif.vs),          32'(e.vs));
        check("small_blank", 32'(sif.blank),       32'(e.blank));
        check("small_fs",    32'(sif.frame_start), 32'(e.fs));
`ifdef VGA_FRAME_CNT_EN
        check("small_fc",    32'(sif.frame_cnt),   32'(e.fc));
`endif
    endtask

    // One pixel clock: push expectations for the coming edge, then pop and
    // compare once the outputs have settled after it.
    task automatic tick();
        exp_t eb, es;
        if (!rst_big) begin
            p_big = BIG_T - 1; fc_big = 0;
        end else begin
            p_big = (p_big + 1) % BIG_T;
            if (p_big == 0) fc_big = (fc_big + 1) % 256;
        end
        if (!rst_small) begin
            p_small = SMALL_T - 1; fc_small = 0;
        end else begin
            p_small = (p_small + 1) % SMALL_T;
            if (p_small == 0) fc_small = (fc_small + 1) % 256;
        end
        q_big.push_back(model(p_big, fc_big, 640, 16, 96, 48, 480, 10, 2, 33));
        q_small.push_back(model(p_small, fc_small, 8, 2, 3, 2, 4, 1, 1, 1));

        @(posedge clk);
        #1;
        cycle++;
        eb = q_big.pop_front();
        es = q_small.pop_front();
        compare_big(eb);
        compare_small(es);

        if (sif.frame_start === 1'b1) begin
            s_pulses++;
            if (s_seen != 0) begin
                check("small_fs_period",   32'(cycle - s_last), 32'd105);
                check("small_blank_count", 32'(s_blank),        32'd32);
                check("small_vs_low",      32'(s_vs_low),       32'd15);
                check("small_hs_low",      32'(s_hs_low),       32'd21);
            end
            s_seen   = 1;
            s_last   = cycle;
            s_blank  = 0;
            s_vs_low = 0;
            s_hs_low = 0;
        end
        if (sif.blank === 1'b1) s_blank++;
        if (sif.vs === 1'b0) s_vs_low++;
        if (sif.hs === 1'b0) s_hs_low++;
    endtask

    task automatic check_big_reset_values(input string tag);
        check({tag, "_x"},     32'(vif.DrawX),       32'd799);
        check({tag, "_y"},     32'(vif.DrawY),       32'd524);
        check({tag, "_hs"},    32'(vif.hs),          32'd1);
        check({tag, "_vs"},    32'(vif.vs),          32'd1);
        check({tag, "_blank"}, 32'(vif.blank),       32'd0);
        check({tag, "_fs"},    32'(vif.frame_start), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        check({tag, "_fc"},    32'(vif.frame_cnt),   32'd0);
`endif
    endtask

    initial begin
        int hs_low;
        int blank_fall_x;
        int hs_rise_x;
        logic prev_hs;

        // Reset held for five cycles on both instances.
        for (int i = 0; i < 5; i++) tick();
        check_big_reset_values("rst");
        check("small_rst_x", 32'(sif.DrawX), 32'd14);
        check("small_rst_y", 32'(sif.DrawY), 32'd6);

        rst_big   = 1'b1;
        rst_small = 1'b1;

        tick();
        check("first_x",     32'(vif.DrawX),       32'd0);
        check("first_y",     32'(vif.DrawY),       32'd0);
        check("first_blank", 32'(vif.blank),       32'd1);
        check("first_fs",    32'(vif.frame_start), 32'd1);
`ifdef VGA_FRAME_CNT_EN
        check("first_fc",    32'(vif.frame_cnt),   32'd1);
`endif
        tick();
        check("second_x",  32'(vif.DrawX),       32'd1);
        check("second_fs", 32'(vif.frame_start), 32'd0);

        // Rest of line 0 with directed landmarks.
        hs_low       = 0;
        blank_fall_x = -1;
        hs_rise_x    = -1;
        prev_hs      = vif.hs;
        for (int i = 0; i < BIG_HT - 2; i++) begin
            tick();
            if (vif.hs === 1'b0) hs_low++;
            if (vif.blank === 1'b0 && blank_fall_x < 0) blank_fall_x = int'(vif.DrawX);
            if (prev_hs === 1'b0 && vif.hs === 1'b1 && hs_rise_x < 0) hs_rise_x = int'(vif.DrawX);
            prev_hs = vif.hs;
        end
        check("line_end_x",   32'(vif.DrawX), 32'd799);
        check("hs_low_count", 32'(hs_low),    32'd96);
        check("blank_fall_x", 32'(blank_fall_x), 32'd640);
        check("hs_rise_x",    32'(hs_rise_x), 32'd752);
        tick();
        check("line_wrap_x", 32'(vif.DrawX), 32'd0);
        check("line_wrap_y", 32'(vif.DrawY), 32'd1);

        // Advance to (300,1), then assert reset between edges.
        for (int i = 0; i < 2000 && !(vif.DrawX == 10'd300 && vif.DrawY == 10'd1); i++) tick();
        check("mid_x", 32'(vif.DrawX), 32'd300);
        check("mid_y", 32'(vif.DrawY), 32'd1);
        rst_big = 1'b0;
        #1;
        check_big_reset_values("async_rst");
        for (int i = 0; i < 3; i++) tick();
        check_big_reset_values("rst_hold");
        rst_big = 1'b1;
        tick();
        check("restart_x",  32'(vif.DrawX),       32'd0);
        check("restart_y",  32'(vif.DrawY),       32'd0);
        check("restart_fs", 32'(vif.frame_start), 32'd1);

`ifdef VGA_FRAME_CNT_EN
        for (int i = 0; i < 30000 && s_pulses < 256; i++) tick();
        check("small_pulses",  32'(s_pulses),      32'd256);
        check("small_fc_wrap", 32'(sif.frame_cnt), 32'd0);
`else
        for (int i = 0; i < 320; i++) tick();
        check("small_pulses_min", 32'(s_pulses >= 3), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
